adc_scan_seq: RTL
=================

// Module: adc_scan_seq
// PURPOSE
//  Channel-scan sequencer directly upstream/downstream of the ADC128S052 serial driver.
//  Drives its enable pulse and 3-bit address; collects its 12-bit result on each done pulse.
//  Tags each result with the correct channel, accounting for the ADC's one-frame address pipeline.
//  Streams tagged samples out through a valid/ready interface.
// PARAMETERS
//  NUM_CH      8     highest channel count scanned; mask width
//  TIMEOUT_CYC 1024  clk cycles to wait for i_ADC_Done before aborting the frame
//  AVG_LOG2    2     log2 of samples averaged per channel (only with ADC_SCAN_AVG_EN)
// PORTS
//  clk            in   1     system clock
//  rst            in   1     synchronous reset, active-high
//  i_start        in   1     pulse: begin one scan (ignored while o_busy)
//  i_continuous   in   1     1: restart scan automatically after last channel
//  i_ch_mask      in   8     bit n=1 -> channel n included; sampled on scan start
//  o_ADC_En       out  1     single-cycle frame start pulse to ADC driver
//  o_ADC_addr     out  3     channel address, held stable from pulse until done
//  i_ADC_Done     in   1     single-cycle frame-complete pulse from driver
//  i_ADC_Dout     in   12    conversion result, valid in the i_ADC_Done cycle
//  o_data         out  12    sample (averaged if enabled)
//  o_ch           out  3     channel the sample belongs to
//  o_valid        out  1     o_data/o_ch valid; held until i_ready
//  i_ready        in   1     downstream accept
//  o_busy         out  1     scan in progress
//  o_timeout_err  out  1     sticky; set on done timeout, cleared by next i_start
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, mask latch 0, accumulator 0.
//  FSM IDLE -> ISSUE -> WAIT -> (PUSH) -> ISSUE... -> IDLE.
//  IDLE: on i_start with mask!=0 -> latch mask, clear err, o_busy=1, ISSUE.
//    Mask==0: stay IDLE, no pulse.
//  ISSUE: o_ADC_En=1 for exactly one cycle; o_ADC_addr = next enabled channel, ascending,
//    wrapping; the held tag = previous frame's address -> WAIT.
//  ADC pipeline: frame k returns the channel addressed in frame k-1.
//    First frame of a scan is a dummy; its result is discarded.
//    After the last enabled channel, one extra flush frame (addr = first enabled channel)
//      collects the last result.
//  WAIT: timer counts.
//    On i_ADC_Done: capture i_ADC_Dout; dummy -> ISSUE, else -> PUSH.
//    Timer reaching TIMEOUT_CYC-1: set o_timeout_err, drop frame, -> IDLE, o_busy=0.
//  PUSH: o_valid=1, o_data/o_ch stable until i_valid&&i_ready handshake (same-cycle accept legal).
//    Then: more channels -> ISSUE; flush done & i_continuous -> ISSUE (new dummy frame, re-latch mask);
//    else -> IDLE.
//  i_ready low stalls the scan; no sample is lost or overwritten.
//  Single enabled channel: dummy, then each frame yields that channel.
//  i_ADC_Done outside WAIT: ignored.
//  i_start while busy: ignored.
//  rst mid-frame: immediate IDLE; the in-flight driver frame completes but its done is ignored.
// CONFIGURATION
//  ADC_SCAN_AVG_EN defined:
//    Each channel is converted 2^AVG_LOG2 consecutive times: same addr, one dummy.
//    Results summed in a (12+AVG_LOG2)-bit accumulator; o_data = sum >> AVG_LOG2 (truncate).
//    One PUSH per channel.
//  ADC_SCAN_AVG_EN undefined: one conversion per channel, no accumulator logic.
// STRUCTURE
//  Package adc_scan_pkg:
//    FSM state encoding; ADC_DW=12; ADC_AW=3.
//    Priority-next-channel function (mask, current) -> next index.
//  One sub-module adc_scan_timeout: loadable down-counter with expiry flag.
// TESTING
//  1. mask=8'b0000_0101, i_start, ready=1, ADC model returns {9'b0,addr_prev}:
//     3 frames; outputs (ch0,0),(ch2,2); busy drops.
//  2. mask=8'h80, continuous=1: pulses with addr 7 repeat; every o_ch=7; en pulses exactly 1 cycle.
//  3. mask=8'h03, ready held 0 for 50 cycles: o_valid, o_data, o_ch stable; no new En until accept.
//  4. Model never returns done, TIMEOUT_CYC=16: err=1 after 16 cycles in WAIT.
//     busy=0; next i_start clears err.
//  5. AVG_EN, AVG_LOG2=2, ch3 returns 100,101,102,103: o_data=101, o_ch=3.
//  6. rst asserted in WAIT, then done pulse: no o_valid; all outputs 0; mask=0 start: no En.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared widths, FSM encoding and next-channel search for the ADC scan sequencer
package adc_scan_pkg;
  localparam int ADC_DW = 12;
  localparam int ADC_AW = 3;
  localparam int CH_MAX = 8;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_PUSH} state_e;
  // Lowest enabled channel strictly after cur, wrapping modulo n; cur itself if it is the only one.
  function automatic logic [ADC_AW-1:0] next_ch(input logic [CH_MAX-1:0] mask,
                                                input logic [ADC_AW-1:0] cur, input int n);
    logic [ADC_AW-1:0] idx;
    next_ch = cur;
    for (int i = CH_MAX; i >= 1; i--) begin
      idx = ADC_AW'((int'(cur) + i) % n);
      if (i <= n && mask[idx]) next_ch = idx;
    end
  endfunction
endpackage

// File: rtl/adc_scan_seq_if.sv
// adc_scan_seq_if: tagged-sample valid/ready stream out of the scan sequencer
interface adc_scan_seq_if;
  import adc_scan_pkg::*;
  logic [ADC_DW-1:0] data;
  logic [ADC_AW-1:0] ch;
  logic valid;
  logic ready;
  modport master(output data, ch, valid, input ready);
  modport slave(input data, ch, valid, output ready);
endinterface

// File: rtl/adc_scan_timeout.sv
// adc_scan_timeout: loadable down-counter, expired while the count sits at zero
module adc_scan_timeout #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? W'(TIMEOUT_CYC - 1) : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/adc_scan_seq.sv
// adc_scan_seq: ADC128S052 channel-scan sequencer with pipelined channel tagging.
// Define ADC_SCAN_AVG_EN to average 2^AVG_LOG2 conversions per channel.
module adc_scan_seq import adc_scan_pkg::*; #(
  parameter int NUM_CH = 8,
`ifdef ADC_SCAN_AVG_EN
  parameter int AVG_LOG2 = 2,
`endif
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_continuous,
  input  logic [NUM_CH-1:0] i_ch_mask,
  output logic              o_ADC_En,
  output logic [ADC_AW-1:0] o_ADC_addr,
  input  logic              i_ADC_Done,
  input  logic [ADC_DW-1:0] i_ADC_Dout,
  adc_scan_seq_if.master    st,
  output logic              o_busy,
  output logic              o_timeout_err
);
  state_e state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d, go_mask;
  logic [ADC_AW-1:0] addr_q, addr_d, tag_q, tag_d, ch_q, ch_d, nxt;
  logic [ADC_DW-1:0] data_q, data_d;
  logic dummy_q, dummy_d, flush_q, flush_d, err_q, err_d;
  logic go, first, expired;
`ifdef ADC_SCAN_AVG_EN
  logic [AVG_LOG2-1:0] rep_q, rep_d;
  logic [ADC_DW+AVG_LOG2-1:0] acc_q, acc_d, acc_sum;
`endif
  adc_scan_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk(clk), .rst(rst), .load(state_q == S_ISSUE), .en(state_q == S_WAIT), .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    addr_d = addr_q;
    tag_d = tag_q;
    ch_d = ch_q;
    data_d = data_q;
    dummy_d = dummy_q;
    flush_d = flush_q;
    err_d = err_q;
    go = 1'b0;
    first = 1'b0;
    go_mask = mask_q;
`ifdef ADC_SCAN_AVG_EN
    rep_d = rep_q;
    acc_d = acc_q;
    acc_sum = acc_q + {{AVG_LOG2{1'b0}}, i_ADC_Dout};
`endif
    case (state_q)
      S_IDLE: if (i_start && i_ch_mask != '0) begin
        go = 1'b1;
        first = 1'b1;
        go_mask = i_ch_mask;
        err_d = 1'b0;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: if (i_ADC_Done) begin
`ifdef ADC_SCAN_AVG_EN
        if (dummy_q) begin
          dummy_d = 1'b0;
          state_d = S_ISSUE;
        end else if (&rep_q) begin
          data_d = acc_sum[ADC_DW+AVG_LOG2-1:AVG_LOG2];
          ch_d = tag_q;
          state_d = S_PUSH;
        end else begin
          acc_d = acc_sum;
          rep_d = rep_q + 1'b1;
          state_d = S_ISSUE;
        end
`else
        if (dummy_q) go = 1'b1;
        else begin
          data_d = i_ADC_Dout;
          ch_d = tag_q;
          state_d = S_PUSH;
        end
`endif
      end else if (expired) begin
        err_d = 1'b1;
        state_d = S_IDLE;
      end
      S_PUSH: if (st.ready) begin
        if (!flush_q) go = 1'b1;
        else if (i_continuous && i_ch_mask != '0) begin
          go = 1'b1;
          first = 1'b1;
          go_mask = i_ch_mask;
        end else state_d = S_IDLE;
      end
    endcase
    nxt = next_ch(CH_MAX'(go_mask), first ? ADC_AW'(NUM_CH - 1) : addr_q, NUM_CH);
    if (go) begin
      state_d = S_ISSUE;
      mask_d = go_mask;
      addr_d = nxt;
`ifdef ADC_SCAN_AVG_EN
      tag_d = nxt;
      dummy_d = 1'b1;
      flush_d = next_ch(CH_MAX'(go_mask), nxt, NUM_CH) <= nxt;
      rep_d = '0;
      acc_d = '0;
`else
      // The ADC returns the previous frame's channel; wrapping back marks the flush frame.
      tag_d = addr_q;
      dummy_d = first;
      flush_d = !first && nxt <= addr_q;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q <= '0;
      addr_q <= '0;
      tag_q <= '0;
      ch_q <= '0;
      data_q <= '0;
      dummy_q <= 1'b0;
      flush_q <= 1'b0;
      err_q <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      rep_q <= '0;
      acc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      addr_q <= addr_d;
      tag_q <= tag_d;
      ch_q <= ch_d;
      data_q <= data_d;
      dummy_q <= dummy_d;
      flush_q <= flush_d;
      err_q <= err_d;
`ifdef ADC_SCAN_AVG_EN
      rep_q <= rep_d;
      acc_q <= acc_d;
`endif
    end
  end
  assign o_ADC_En = state_q == S_ISSUE;
  assign o_ADC_addr = addr_q;
  assign st.data = data_q;
  assign st.ch = ch_q;
  assign st.valid = state_q == S_PUSH;
  assign o_busy = state_q != S_IDLE;
  assign o_timeout_err = err_q;
endmodule
